// File: rtl/des_key_scheduler_if.sv
// Controller <-> key scheduler bundle: schedule control inputs and round-key outputs.
interface des_key_scheduler_if;
  logic        des_start;
  logic        count_enable;
  logic        reverse;
  logic [63:0] key_in;
  logic [47:0] subkey;
  logic [3:0]  round_num;
  logic        key_valid;
  logic        key_rollover;

  modport master (
    output des_start, count_enable, reverse, key_in,
    input  subkey, round_num, key_valid, key_rollover
  );

  modport slave (
    input  des_start, count_enable, reverse, key_in,
    output subkey, round_num, key_valid, key_rollover
  );
endinterface

// File: rtl/des_key_scheduler.sv
// DES round-key generator: PC-1 load, per-round C/D rotation (forward or reverse order), PC-2 output.
module des_key_scheduler (
  input  logic                   clk,
  input  logic                   n_rst,
  des_key_scheduler_if.slave     bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // FIPS 46-3 tables; entry values use bit 1 = MSB numbering.
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  logic [1:0]  state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [4:0]  r_q, r_d;
  logic        mode_q, mode_d;

  logic [55:0] pc1_cd;
  logic [55:0] cd_cur;
  logic [47:0] pc2_out;
  logic [4:0]  r_next;
  logic [4:0]  dec_idx;

  assign cd_cur = {c_q, d_q};

  for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
    assign pc1_cd[55-gi] = bus.key_in[64-PC1_TBL[gi]];
  end

  for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
    assign pc2_out[47-gi] = cd_cur[56-PC2_TBL[gi]];
  end

  // Rounds 1, 2, 9 and 16 shift by one; all others by two.
  function automatic logic shift_is_two(input logic [4:0] idx);
    shift_is_two = !((idx == 5'd1) || (idx == 5'd2) || (idx == 5'd9) || (idx == 5'd16));
  endfunction

  function automatic logic [27:0] rot_left(input logic [27:0] x, input logic two);
    rot_left = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rot_right(input logic [27:0] x, input logic two);
    rot_right = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  assign r_next  = r_q + 5'd1;
  assign dec_idx = 5'd18 - r_next;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    r_d     = r_q;
    mode_d  = mode_q;
    if (bus.des_start) begin
      state_d = ST_ACTIVE;
      c_d     = pc1_cd[55:28];
      d_d     = pc1_cd[27:0];
      r_d     = 5'd0;
      mode_d  = bus.reverse;
    end else if (bus.count_enable && (state_q == ST_ACTIVE) && (r_q < 5'd16)) begin
      r_d = r_next;
      if (!mode_q) begin
        c_d = rot_left(c_q, shift_is_two(r_next));
        d_d = rot_left(d_q, shift_is_two(r_next));
      end else if (r_next != 5'd1) begin
        // Decrypt walks the encrypt rotations backwards; round 1 uses the unrotated
        // PC-1 value, which equals C16/D16 since the total shift is a full 28.
        c_d = rot_right(c_q, shift_is_two(dec_idx));
        d_d = rot_right(d_q, shift_is_two(dec_idx));
      end
      if (r_next == 5'd16) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.subkey       = pc2_out;
  assign bus.round_num    = r_q[3:0];
  assign bus.key_valid    = (r_q != 5'd0);
  assign bus.key_rollover = (state_q == ST_DONE);

endmodule

// File: tb/tb_des_key_scheduler.sv
// Randomized check of des_key_scheduler against a whole-schedule reference model, plus pinned DES vectors.
module tb_des_key_scheduler;

  typedef logic [16:1][47:0] keys_t;

  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_STD  = 48'h1B02EFFC7072;
  localparam logic [47:0] K2_STD  = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16_STD = 48'hCB3D8B0E17F5;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  des_key_scheduler_if bus();

  des_key_scheduler dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference: all sixteen round keys from cumulative shifts applied to PC-1(key).
  function automatic keys_t des_keys(input logic [63:0] key);
    int pc1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                     10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                     23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48,
                     44,49,39,56,34,53, 46,42,50,36,29,32};
    int sh [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    bit cd0 [56];
    keys_t ks;
    int t, p, src;
    for (int i = 0; i < 56; i++) cd0[i] = key[64 - pc1[i]];
    t = 0;
    ks = '0;
    for (int r = 1; r <= 16; r++) begin
      t = t + sh[r-1];
      for (int j = 0; j < 48; j++) begin
        p = pc2[j] - 1;
        src = (p < 28) ? ((p + t) % 28) : (28 + ((p - 28 + t) % 28));
        ks[r][47-j] = cd0[src];
      end
    end
    return ks;
  endfunction

  bit    m_started = 1'b0;
  int    m_r       = 0;
  bit    m_rev     = 1'b0;
  keys_t m_keys    = '0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_started <= 1'b0;
      m_r       <= 0;
      m_rev     <= 1'b0;
      m_keys    <= '0;
    end else if (bus.des_start) begin
      m_started <= 1'b1;
      m_r       <= 0;
      m_rev     <= bus.reverse;
      m_keys    <= des_keys(bus.key_in);
    end else if (bus.count_enable && m_started && m_r < 16) begin
      m_r <= m_r + 1;
    end
  end

  logic [47:0] e_sub;
  logic [3:0]  e_round;
  logic        e_valid, e_roll;

  always @(negedge clk) begin
    if (!m_started)     e_sub = '0;
    else if (m_r == 0)  e_sub = m_keys[16];
    else if (m_rev)     e_sub = m_keys[17 - m_r];
    else                e_sub = m_keys[m_r];
    e_round = 4'(m_r % 16);
    e_valid = (m_r != 0);
    e_roll  = (m_r == 16);
    n_vec++;
    if (bus.subkey !== e_sub || bus.round_num !== e_round ||
        bus.key_valid !== e_valid || bus.key_rollover !== e_roll) begin
      n_miss++;
      $display("FAIL model t=%0t got sub=%h rnd=%0d v=%b ro=%b expected sub=%h rnd=%0d v=%b ro=%b",
               $time, bus.subkey, bus.round_num, bus.key_valid, bus.key_rollover,
               e_sub, e_round, e_valid, e_roll);
    end
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic st, input logic ce, input logic rev, input logic [63:0] key);
    bus.des_start    = st;
    bus.count_enable = ce;
    bus.reverse      = rev;
    bus.key_in       = key;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_sub"},   bus.subkey, 48'h0);
    chk({name, "_round"}, 48'(bus.round_num), 48'h0);
    chk({name, "_valid"}, 48'(bus.key_valid), 48'h0);
    chk({name, "_roll"},  48'(bus.key_rollover), 48'h0);
  endtask

  logic [63:0] rkey;

  initial begin
    bus.des_start = 1'b0; bus.count_enable = 1'b0; bus.reverse = 1'b0; bus.key_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    n_rst = 1'b1;

    // count_enable while idle is ignored
    repeat (3) cycle(1'b0, 1'b1, 1'b0, KEY_STD);
    chk_zero("idle_ce");

    // Encrypt run with the standard vector
    cycle(1'b1, 1'b0, 1'b0, KEY_STD);
    chk("enc_load_valid", 48'(bus.key_valid), 48'h0);
    cycle(1'b0, 1'b1, 1'b0, KEY_STD);
    chk("enc_k1", bus.subkey, K1_STD);
    chk("enc_r1", 48'(bus.round_num), 48'd1);
    cycle(1'b0, 1'b1, 1'b0, KEY_STD);
    chk("enc_k2", bus.subkey, K2_STD);
    repeat (14) cycle(1'b0, 1'b1, 1'b0, KEY_STD);
    chk("enc_k16", bus.subkey, K16_STD);
    chk("enc_r16", 48'(bus.round_num), 48'd0);
    chk("enc_roll", 48'(bus.key_rollover), 48'h1);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, KEY_STD);
    chk("hold_k16", bus.subkey, K16_STD);
    chk("hold_roll", 48'(bus.key_rollover), 48'h1);
    chk("hold_round", 48'(bus.round_num), 48'd0);

    // Decrypt run
    cycle(1'b1, 1'b0, 1'b1, KEY_STD);
    cycle(1'b0, 1'b1, 1'b0, KEY_STD);
    chk("dec_first", bus.subkey, K16_STD);
    repeat (15) cycle(1'b0, 1'b1, 1'b0, KEY_STD);
    chk("dec_last", bus.subkey, K1_STD);
    chk("dec_roll", 48'(bus.key_rollover), 48'h1);

    // Restart mid-schedule with a new key; then start and count together
    cycle(1'b1, 1'b0, 1'b0, KEY_STD);
    repeat (7) cycle(1'b0, 1'b1, 1'b0, KEY_STD);
    rkey = {$urandom, $urandom};
    cycle(1'b1, 1'b0, 1'b0, rkey);
    chk("restart_round", 48'(bus.round_num), 48'd0);
    chk("restart_valid", 48'(bus.key_valid), 48'h0);
    chk("restart_roll", 48'(bus.key_rollover), 48'h0);
    cycle(1'b0, 1'b1, 1'b0, rkey);
    cycle(1'b1, 1'b1, 1'b0, KEY_STD);
    chk("start_wins_round", 48'(bus.round_num), 48'd0);
    chk("start_wins_sub", bus.subkey, K16_STD);

    // Asynchronous reset at round 9
    repeat (9) cycle(1'b0, 1'b1, 1'b0, KEY_STD);
    bus.count_enable = 1'b0;
    #2 n_rst = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (3) cycle(1'b0, 1'b1, 1'b0, KEY_STD);
    chk_zero("post_rst_ce");

    // Input churn during an encrypt run does not disturb the schedule
    cycle(1'b1, 1'b0, 1'b0, KEY_STD);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, i[0], {$urandom, $urandom});
      if (i == 1)  chk("churn_k1", bus.subkey, K1_STD);
      if (i == 2)  chk("churn_k2", bus.subkey, K2_STD);
      if (i == 16) chk("churn_k16", bus.subkey, K16_STD);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
      end else begin
        cycle(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, {$urandom, $urandom});
      end
    end

    cycle(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/des_key_scheduler.md
DES_KEY_SCHEDULER -- requirements
Module: des_key_scheduler

Interface
REQ-001: clk  input  1  system clock; all state updates on rising edge.
REQ-002: n_rst  input  1  asynchronous, active-low reset.
REQ-003: des_start  input  1  one-cycle pulse from the DES control unit; loads a new key and restarts the schedule.
REQ-004: count_enable  input  1  one-cycle pulse; advances the schedule by one round.
REQ-005: reverse  input  1  direction: 0 = encrypt order (K1..K16), 1 = decrypt order (K16..K1); sampled only on des_start.
REQ-006: key_in  input  64  DES key; bit 1 (FIPS 46-3 numbering) = key_in[63]; parity bits ignored.
REQ-007: subkey  output  48  round subkey; bit 1 = subkey[47].
REQ-008: round_num  output  4  current round, 0 = none, 1..16; value 16 encoded as 4'd0 with key_rollover high.
REQ-009: key_valid  output  1  high when subkey holds a valid round key.
REQ-010: key_rollover  output  1  level, high once round 16 is reached; tells the controller that all rounds are done.

Function
REQ-011: Internal state SHALL be C and D (28 bits each), latched mode bit, 5-bit round counter r (0..16), and FSM {IDLE, ACTIVE, DONE}.
REQ-012: des_start in any state SHALL do the following on the next edge:
- load C||D = PC-1(key_in);
- set r = 0;
- latch mode = reverse;
- go to ACTIVE.
REQ-013: Shift schedule S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-014: count_enable in ACTIVE with r < 16 SHALL increment r, with r' = r+1, and update C,D in the same edge as follows:
- encrypt: rotate C and D left by S[r'];
- decrypt, r' = 1: no rotation;
- decrypt, r' > 1: rotate C and D right by S[18-r'].
REQ-015: subkey SHALL be PC-2(C||D) combinationally from the registered C,D. Round r therefore presents K_r in encrypt mode and K_(17-r) in decrypt mode.
REQ-016: key_valid SHALL be 1 when r is in 1..16 and 0 otherwise.
REQ-017: When r reaches 16, FSM SHALL enter DONE. In DONE, key_rollover = 1 and is held until the next des_start or reset.
REQ-018: In DONE, count_enable SHALL be ignored: no wrap, and C, D and r are unchanged.
REQ-019: In IDLE, count_enable SHALL be ignored and all outputs stay at reset values.
REQ-020: des_start and count_enable asserted in the same cycle: des_start SHALL win, giving r = 0 and no rotation.
REQ-021: Changes on reverse or key_in between des_start pulses SHALL have no effect on the schedule in progress.
REQ-022: Latency: des_start to key_valid SHALL be 2 edges minimum (load, then first count_enable). Each count_enable SHALL produce its new subkey in the cycle after the edge.
REQ-023: All outputs SHALL be glitch-free functions of registered state only. No combinational path from the inputs to any output.

Reset
REQ-024: On n_rst low, immediately and regardless of clk:
- FSM = IDLE;
- C, D, r and mode = 0;
- subkey = 48'h0, round_num = 0, key_valid = 0, key_rollover = 0.
REQ-025: Reset asserted mid-schedule SHALL abandon the schedule. After release, the block stays in IDLE until des_start.

Verification
REQ-026: Encrypt, key_in = 64'h133457799BBCDFF1:
- des_start with reverse=0, then 1 count_enable -> subkey = 48'h1B02EFFC7072, round_num = 1;
- next count_enable -> 48'h79AED9DBC9E5;
- 16th count_enable -> 48'hCB3D8B0E17F5 and key_rollover = 1.
REQ-027: Decrypt, same key with reverse=1:
- first count_enable -> subkey = 48'hCB3D8B0E17F5;
- 16th count_enable -> 48'h1B02EFFC7072 and key_rollover = 1.
REQ-028: 17th and 20th count_enable after rollover -> subkey, round_num and key_rollover unchanged.
REQ-029: des_start at round 7 with a new key and reverse=0 -> r = 0, key_rollover = 0, key_valid = 0. Next count_enable -> K1 of the new key. Also assert des_start and count_enable together: no rotation occurs.
REQ-030: Reset pulse at round 9 -> all outputs 0 asynchronously. count_enable pulses before des_start leave outputs at 0.
REQ-031: Toggle reverse and key_in every cycle during an encrypt run of 16 rounds -> subkey sequence identical to REQ-026.
